// File: rtl/jt900h_intctrl_pkg.sv
// Shared definitions for the jt900h interrupt controller.
// Register word indices, datapath widths and FSM state encoding.
package jt900h_intctrl_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned LVL_W  = 3;
  localparam int unsigned IDX_W  = 3;

  localparam logic [ADDR_W-1:0] REG_PEND   = 3'd0;
  localparam logic [ADDR_W-1:0] REG_ENABLE = 3'd1;
  localparam logic [ADDR_W-1:0] REG_LVL0   = 3'd2;
  localparam logic [ADDR_W-1:0] REG_LVL1   = 3'd3;
  localparam logic [ADDR_W-1:0] REG_STATUS = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/jt900h_intctrl_prio.sv
// Combinational priority encoder for the interrupt controller.
// Ports:
//   pend_i  - pending bit per source
//   en_i    - enable bit per source
//   lvl_i   - 3-bit level per source, source i at [3*i +: 3]
//   valid_o - at least one source is eligible
//   idx_o   - winning source index
//   lvl_o   - winning source level
// Highest level wins; ties resolve to the lowest index. Level 0 is masked.
module jt900h_intctrl_prio
  import jt900h_intctrl_pkg::*;
#(
  parameter int unsigned NSRC = 8
) (
  input  logic [NSRC-1:0]       pend_i,
  input  logic [NSRC-1:0]       en_i,
  input  logic [3*NSRC-1:0]     lvl_i,
  output logic                  valid_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic [LVL_W-1:0]      lvl_o
);

  logic [IDX_W-1:0] best_idx;
  logic [LVL_W-1:0] best_lvl;

  // Strict compare keeps the first (lowest) index among equal levels
  always_comb begin
    best_idx = '0;
    best_lvl = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (pend_i[i] && en_i[i] && (lvl_i[3*i +: 3] > best_lvl)) begin
        best_idx = IDX_W'(i);
        best_lvl = lvl_i[3*i +: 3];
      end
    end
  end

  assign valid_o = (best_lvl != '0);
  assign idx_o   = best_idx;
  assign lvl_o   = best_lvl;

endmodule

// File: rtl/jt900h_intctrl.sv
// Memory-mapped interrupt controller for the jt900h CPU.
// Ports:
//   clk, rst, cen      - clock, synchronous active-high reset, clock enable
//   src                - rising-edge interrupt sources
//   cs, addr, din, we  - register write port (16-bit, byte enables {hi,lo})
//   dout               - register read data, combinational from addr
//   irq, int_lvl,      - request, level and vector of the presented source
//   int_addr
//   irq_ack            - one-cycle CPU acknowledge
module jt900h_intctrl
  import jt900h_intctrl_pkg::*;
#(
  parameter int unsigned NSRC     = 8,
  parameter logic [7:0]  VEC_BASE = 8'h20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cen,
  input  logic [NSRC-1:0]     src,
  input  logic                cs,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic [1:0]          we,
  output logic [DATA_W-1:0]   dout,
  output logic                irq,
  output logic [LVL_W-1:0]    int_lvl,
  output logic [7:0]          int_addr,
  input  logic                irq_ack
);

  state_e              state_q, state_d;
  logic [NSRC-1:0]     src_q, pend_q, pend_d, en_q, en_d;
  logic [3*NSRC-1:0]   lvl_q, lvl_d;
  logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
  logic [LVL_W-1:0]    cur_lvl_q, cur_lvl_d;
  logic                irq_q, irq_d;

  logic                wr;
  logic [NSRC-1:0]     set_v, wclr_v, aclr_v, elig_v;
  logic                cur_elig;
  logic                p_valid;
  logic [IDX_W-1:0]    p_idx;
  logic [LVL_W-1:0]    p_lvl;
  logic [31:0]         lvl_rd;
  logic                unused_din;

  assign wr         = cs & cen;
  assign unused_din = ^din;

  jt900h_intctrl_prio #(.NSRC(NSRC)) u_prio (
    .pend_i  (pend_q),
    .en_i    (en_q),
    .lvl_i   (lvl_q),
    .valid_o (p_valid),
    .idx_o   (p_idx),
    .lvl_o   (p_lvl)
  );

  // Per-source level write decode, eligibility and read-back packing
  for (genvar g = 0; g < 8; g++) begin : g_src
    if (g < NSRC) begin : g_used
      localparam logic [ADDR_W-1:0] WADDR = ADDR_W'(REG_LVL0 + g / 4);
      localparam int unsigned       FOFS  = 4 * (g % 4);
      localparam int unsigned       BSEL  = (g % 4) / 2;
      assign lvl_d[3*g +: 3] = (wr && addr == WADDR && we[BSEL]) ? din[FOFS +: 3]
                                                                   : lvl_q[3*g +: 3];
      assign elig_v[g]       = pend_q[g] & en_q[g] & (|lvl_q[3*g +: 3]);
      assign lvl_rd[4*g +: 4] = {1'b0, lvl_q[3*g +: 3]};
    end else begin : g_unused
      assign lvl_rd[4*g +: 4] = 4'd0;
    end
  end

  assign cur_elig = |(elig_v & (NSRC'(1) << cur_idx_q));

  // Pending / enable next state; a new edge beats any clear in the same cycle
  always_comb begin
    set_v  = src & ~src_q;
    wclr_v = '0;
    if (wr && addr == REG_PEND && we[0]) wclr_v = din[NSRC-1:0];
    pend_d = (pend_q & ~(wclr_v | aclr_v)) | set_v;
    en_d   = en_q;
    if (wr && addr == REG_ENABLE && we[0]) en_d = din[NSRC-1:0];
  end

  // Request FSM: present one source, hold until ack or loss of eligibility
  always_comb begin
    state_d   = state_q;
    irq_d     = irq_q;
    cur_idx_d = cur_idx_q;
    cur_lvl_d = cur_lvl_q;
    aclr_v    = '0;
    case (state_q)
      IDLE: begin
        if (p_valid) begin
          state_d   = REQ;
          irq_d     = 1'b1;
          cur_idx_d = p_idx;
          cur_lvl_d = p_lvl;
        end
      end
      REQ: begin
        if (irq_ack) begin
          aclr_v  = NSRC'(1) << cur_idx_q;
          irq_d   = 1'b0;
          state_d = GAP;
        end else if (!cur_elig) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end
      end
      GAP: state_d = IDLE;
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      src_q     <= '0;
      pend_q    <= '0;
      en_q      <= '0;
      lvl_q     <= '0;
      cur_idx_q <= '0;
      cur_lvl_q <= '0;
      irq_q     <= 1'b0;
    end else if (cen) begin
      state_q   <= state_d;
      src_q     <= src;
      pend_q    <= pend_d;
      en_q      <= en_d;
      lvl_q     <= lvl_d;
      cur_idx_q <= cur_idx_d;
      cur_lvl_q <= cur_lvl_d;
      irq_q     <= irq_d;
    end
  end

  // Register read mux
  always_comb begin
    dout = '0;
    case (addr)
      REG_PEND:   dout = DATA_W'(pend_q);
      REG_ENABLE: dout = DATA_W'(en_q);
      REG_LVL0:   dout = lvl_rd[15:0];
      REG_LVL1:   dout = lvl_rd[31:16];
      REG_STATUS: dout = {8'd0, (state_q == REQ), 1'b0, cur_idx_q, cur_lvl_q};
      default:    dout = '0;
    endcase
  end

  assign irq      = irq_q;
  assign int_lvl  = cur_lvl_q;
  assign int_addr = {VEC_BASE[7:5], cur_idx_q, 2'b00};

endmodule

// File: tb/tb_jt900h_intctrl.sv
// Self-checking bench for jt900h_intctrl: directed scenarios followed by
// random traffic, every cycle compared against a behavioural model.
module tb_jt900h_intctrl;

  logic        clk = 1'b0;
  logic        rst, cen, cs, irq_ack;
  logic [7:0]  src;
  logic [2:0]  addr;
  logic [15:0] din, dout;
  logic [1:0]  we;
  logic        irq;
  logic [2:0]  int_lvl;
  logic [7:0]  int_addr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jt900h_intctrl #(.NSRC(8), .VEC_BASE(8'h20)) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .src      (src),
    .cs       (cs),
    .addr     (addr),
    .din      (din),
    .we       (we),
    .dout     (dout),
    .irq      (irq),
    .int_lvl  (int_lvl),
    .int_addr (int_addr),
    .irq_ack  (irq_ack)
  );

  // Behavioural model state
  bit m_pend[8];
  bit m_en[8];
  int m_lvl[8];
  bit m_srcq[8];
  bit m_irq;
  bit m_gap;
  int m_cur;
  int m_curlvl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit eligible(int i);
    return m_pend[i] && m_en[i] && (m_lvl[i] != 0);
  endfunction

  function automatic logic [15:0] exp_read(int a);
    logic [15:0] v;
    v = '0;
    case (a)
      0: for (int i = 0; i < 8; i++) v[i] = m_pend[i];
      1: for (int i = 0; i < 8; i++) v[i] = m_en[i];
      2: for (int i = 0; i < 4; i++) v = v | 16'(m_lvl[i] << (4 * i));
      3: for (int i = 0; i < 4; i++) v = v | 16'(m_lvl[i+4] << (4 * i));
      4: v = {8'd0, m_irq, 1'b0, 3'(m_cur), 3'(m_curlvl)};
      default: v = '0;
    endcase
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently driven
  task automatic model_clock();
    bit n_irq, n_gap, ack_hit, clr, set;
    int n_cur, n_lvl, word, fld;
    bit n_pend[8];
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_pend[i] = 0; m_en[i] = 0; m_lvl[i] = 0; m_srcq[i] = 0;
      end
      m_irq = 0; m_gap = 0; m_cur = 0; m_curlvl = 0;
      return;
    end
    if (!cen) return;
    n_irq = m_irq; n_gap = m_gap; n_cur = m_cur; n_lvl = m_curlvl; ack_hit = 0;
    if (m_irq) begin
      if (irq_ack) begin
        ack_hit = 1; n_irq = 0; n_gap = 1;
      end else if (!eligible(m_cur)) begin
        n_irq = 0;
      end
    end else if (m_gap) begin
      n_gap = 0;
    end else begin
      // search levels from highest down, indices from lowest up
      for (int l = 7; l >= 1 && !n_irq; l--)
        for (int i = 0; i < 8 && !n_irq; i++)
          if (eligible(i) && m_lvl[i] == l) begin
            n_irq = 1; n_cur = i; n_lvl = l;
          end
    end
    for (int i = 0; i < 8; i++) begin
      clr = (ack_hit && i == m_cur) || (cs && addr == 3'd0 && we[0] && din[i]);
      set = src[i] && !m_srcq[i];
      n_pend[i] = set || (m_pend[i] && !clr);
    end
    for (int i = 0; i < 8; i++) begin
      word = 2 + i / 4;
      fld  = i % 4;
      if (cs && int'(addr) == 1 && we[0]) m_en[i] = din[i];
      if (cs && int'(addr) == word && we[fld / 2]) m_lvl[i] = int'((din >> (4 * fld)) & 16'h7);
      m_pend[i] = n_pend[i];
      m_srcq[i] = src[i];
    end
    m_irq = n_irq; m_gap = n_gap; m_cur = n_cur; m_curlvl = n_lvl;
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
    check("irq", 32'(irq), 32'(m_irq));
    check("int_lvl", 32'(int_lvl), 32'(m_curlvl));
    check("int_addr", 32'(int_addr), 32'(32'h20 + m_cur * 4));
    check("dout", 32'(dout), 32'(exp_read(int'(addr))));
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] w);
    cs = 1'b1; addr = a; din = d; we = w;
    step();
    cs = 1'b0; we = 2'b00;
  endtask

  task automatic peek(input string tag, input logic [2:0] a, input logic [15:0] exp);
    addr = a;
    #1;
    check(tag, 32'(dout), 32'(exp));
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; cs = 1'b0; irq_ack = 1'b0;
    src = '0; addr = '0; din = '0; we = '0;
    step(); step();
    rst = 1'b0;
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_int_addr", 32'(int_addr), 32'h20);
    peek("rst_pend", 3'd0, 16'h0000);

    // 1: single source, latency and GAP
    wr(3'd1, 16'h0001, 2'b01);
    wr(3'd2, 16'h0003, 2'b01);
    src[0] = 1'b1; step();
    check("t1_not_yet", 32'(irq), 32'd0);
    step();
    check("t1_irq", 32'(irq), 32'd1);
    check("t1_lvl", 32'(int_lvl), 32'd3);
    check("t1_addr", 32'(int_addr), 32'h20);
    src[0] = 1'b0; step();
    ack();
    check("t1_ack_irq", 32'(irq), 32'd0);
    peek("t1_pend", 3'd0, 16'h0000);
    step();
    check("t1_gap_irq", 32'(irq), 32'd0);

    // 2: level priority
    wr(3'd1, 16'h0006, 2'b01);
    wr(3'd2, 16'h0520, 2'b11);
    src[1] = 1'b1; src[2] = 1'b1; step(); step();
    check("t2_first_addr", 32'(int_addr), 32'h28);
    check("t2_first_lvl", 32'(int_lvl), 32'd5);
    src = '0; ack(); step(); step();
    check("t2_second_addr", 32'(int_addr), 32'h24);
    check("t2_second_lvl", 32'(int_lvl), 32'd2);
    ack(); step();

    // 3: tie on level goes to lowest index
    wr(3'd1, 16'h000A, 2'b01);
    wr(3'd2, 16'h4040, 2'b11);
    src[1] = 1'b1; src[3] = 1'b1; step(); step();
    check("t3_first_addr", 32'(int_addr), 32'h24);
    src = '0; ack(); step(); step();
    check("t3_second_addr", 32'(int_addr), 32'h2C);
    ack(); step();

    // 4: disable while requesting, then re-enable
    wr(3'd1, 16'h0001, 2'b01);
    wr(3'd2, 16'h0003, 2'b01);
    src[0] = 1'b1; step(); step();
    check("t4_irq", 32'(irq), 32'd1);
    wr(3'd1, 16'h0000, 2'b01);
    step();
    check("t4_dropped", 32'(irq), 32'd0);
    peek("t4_pend", 3'd0, 16'h0001);
    peek("t4_status", 3'd4, {8'd0, 1'b0, 1'b0, 3'd0, 3'd3});
    wr(3'd1, 16'h0001, 2'b01);
    step();
    check("t4_reissue", 32'(irq), 32'd1);
    ack(); step();

    // 5: edge beats same-cycle clear; level 0 masks
    src[0] = 1'b0; step();
    src[0] = 1'b1;
    wr(3'd0, 16'h0001, 2'b01);
    peek("t5_set_wins", 3'd0, 16'h0001);
    step(); ack(); step();
    wr(3'd2, 16'h0000, 2'b11);
    wr(3'd1, 16'h0002, 2'b01);
    src[1] = 1'b1; step(); step(); step();
    check("t5_masked_irq", 32'(irq), 32'd0);
    peek("t5_masked_pend", 3'd0, 16'h0002);

    // 6: reset mid-request, then cen freeze
    wr(3'd2, 16'h0010, 2'b01);
    step();
    check("t6_req", 32'(irq), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    check("t6_rst_irq", 32'(irq), 32'd0);
    peek("t6_rst_pend", 3'd0, 16'h0000);
    peek("t6_rst_en", 3'd1, 16'h0000);
    peek("t6_rst_status", 3'd4, 16'h0000);
    src = '0; step();
    cen = 1'b0; src = 8'hFF;
    wr(3'd1, 16'h00FF, 2'b01);
    step(); step();
    peek("t6_cen_pend", 3'd0, 16'h0000);
    peek("t6_cen_en", 3'd1, 16'h0000);
    cen = 1'b1; src = '0; step();

    // Random traffic
    wr(3'd1, 16'h00FF, 2'b01);
    wr(3'd2, 16'($urandom), 2'b11);
    wr(3'd3, 16'($urandom), 2'b11);
    for (int k = 0; k < 600; k++) begin
      cen = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 2) == 0) src[$urandom_range(0, 7)] ^= 1'b1;
      cs   = ($urandom_range(0, 4) == 0);
      addr = 3'($urandom_range(0, 7));
      din  = 16'($urandom);
      we   = 2'($urandom_range(0, 3));
      irq_ack = irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      step();
    end
    rst = 1'b0; cs = 1'b0; irq_ack = 1'b0; cen = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jt900h_intctrl.md
Name: jt900h_intctrl

Overview:
Memory-mapped interrupt controller that schedules up to eight external interrupt sources onto the single jt900h irq/int_lvl/int_addr/irq_ack interface.
- Latches source rising edges as pending.
- Applies a per-source enable and a per-source 3-bit level.
- Picks the highest-priority pending source and holds the CPU request until irq_ack.
- Sits beside the CPU on the 16-bit data bus. It replaces the bench-side interrupt generator in system builds.

Parameters:
- NSRC, 8, number of interrupt sources (1..8).
- VEC_BASE, 8'h20, vector base; int_addr = {VEC_BASE[7:5], src_idx[2:0], 2'b00}.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cen  in  1  clock enable; all state updates occur only when cen=1
- src  in  NSRC  interrupt source lines, rising-edge sensitive
- cs  in  1  register select, decoded externally
- addr  in  3  word register index
- din  in  16  CPU write data
- we  in  2  byte write enables {high,low}
- dout  out  16  register read data, combinational from addr
- irq  out  1  interrupt request to CPU
- int_lvl  out  3  level of the presented source
- int_addr  out  8  vector address of the presented source
- irq_ack  in  1  CPU acknowledge, one cycle

Behaviour:
Register map (word index):
- 0 PEND: read shows pending bits. A low-byte write of 1 clears the matching bit.
- 1 ENABLE: read/write; bit i enables source i.
- 2 LVL0: 4-bit fields, one per source 0..3; bits [2:0] are the level, bit 3 reads 0.
- 3 LVL1: same layout for sources 4..7.
- 4 STATUS: read only = {8'd0, busy, 1'b0, cur_idx[2:0], cur_lvl[2:0]}.
- 5..7: read 0; writes ignored.

Byte writes:
- we[0] updates bits [7:0]; we[1] updates bits [15:8].
- Bits at or above NSRC are tied to 0.

Reset values:
- irq=0, int_lvl=0, int_addr={VEC_BASE[7:5],5'd0}.
- PEND=0, ENABLE=0, LVL=0, source edge registers=0, state=IDLE.

Edge detection:
- pend[i] is set on a cen cycle where src[i]=1 and src_q[i]=0.
- When a set and a clear (PEND write or ack) hit the same bit in the same cycle, set wins.

Eligibility and priority:
- Source i is eligible when pend[i] & en[i] & lvl[i]!=0. Level 0 means masked.
- Winner is the highest level; ties go to the lowest index.

FSM (advances on cen):
- IDLE: if any source is eligible, latch its idx and level, drive irq=1, int_lvl, int_addr, then go to REQ. The eligible-to-irq latency is 1 cen cycle.
- REQ:
  - outputs stay stable and there is no preemption by a higher-priority arrival;
  - on irq_ack, clear pend[cur_idx], drop irq, go to GAP;
  - if the current source loses eligibility (disabled, level set to 0, or PEND cleared by write) before ack, drop irq and go to IDLE;
  - irq_ack seen in IDLE or GAP is ignored.
- GAP: one cycle with irq=0, then IDLE. This guarantees a deassertion between back-to-back requests.

Other conditions:
- cen=0 freezes all state and edge capture.
- Reset mid-request drops irq the next clock; pending edges are lost.

Decomposition:
- Package jt900h_intctrl_pkg: register index constants (REG_PEND..REG_STATUS) and FSM state encoding (IDLE, REQ, GAP).
- Sub-module jt900h_intctrl_prio: combinational priority encoder. It takes pend, en and lvl vectors and returns valid, idx[2:0] and lvl[2:0].

Test Plan:
1. ENABLE=0x01, LVL0=0x0003, pulse src[0] -> next cen cycle irq=1, int_lvl=3, int_addr=0x20. Ack -> PEND=0, irq=0 for one GAP cycle.
2. ENABLE=0x06, src1 at level 2 and src2 at level 5, same-cycle edges -> src2 is served first (int_addr=0x28). After ack and GAP, src1 is served (int_addr=0x24, lvl 2).
3. src1 and src3 both at level 4, simultaneous edges -> src1 is served first, src3 second.
4. While in REQ for src0, write ENABLE=0 -> irq=0 next cycle, state=IDLE, PEND bit0 still 1. Re-enable -> request reissued.
5. src0 edge in the same cycle as a PEND write of 0x0001 -> PEND bit0 stays 1. An edge on a source with lvl=0 -> pending but irq stays 0.
6. Assert rst during REQ -> irq=0, PEND=ENABLE=0, STATUS=0. cen held low -> no edges captured and no FSM movement.
